// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: input conditioning, 11-bit frame decode with
// parity/stop checking, abort timeout, and a first-word-fall-through result FIFO.
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          kb_clk,
    input  logic                          kb_data,
    input  logic                          rx_ready,
    input  logic                          clr_ovf,
    output logic                          rx_valid,
    output logic [7:0]                    rx_data,
    output logic                          rx_perr,
    output logic                          rx_ferr,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          rx_overflow,
    output logic                          rx_timeout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    function automatic logic parity_err(input logic [7:0] d, input logic p);
        return ~(^d ^ p);
    endfunction

    logic          kb_clk_p0, kb_clk_p1, kb_data_p0, kb_data_p1;
    logic [FW-1:0] flt_cnt;
    logic          kb_clk_flt, kb_clk_flt_d;
    logic          edge_e, bit_b;

    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic          timeout_hit;
    logic          push_vld_p1;

    logic [7:0]    shift_p0;
    logic          perr_p0;
    logic [9:0]    push_word_p1;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, pop, push_ok, ovf_set;
    logic [9:0]    head;

    // Stage: 2-FF synchronisers, idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kb_clk_p0  <= 1'b1;
            kb_clk_p1  <= 1'b1;
            kb_data_p0 <= 1'b1;
            kb_data_p1 <= 1'b1;
        end else begin
            kb_clk_p0  <= kb_clk;
            kb_clk_p1  <= kb_clk_p0;
            kb_data_p0 <= kb_data;
            kb_data_p1 <= kb_data_p0;
        end
    end

    // Stage: glitch filter, level only follows after FILTER_LEN differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flt_cnt      <= '0;
            kb_clk_flt   <= 1'b1;
            kb_clk_flt_d <= 1'b1;
        end else begin
            kb_clk_flt_d <= kb_clk_flt;
            if (kb_clk_p1 == kb_clk_flt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                flt_cnt    <= '0;
                kb_clk_flt <= kb_clk_p1;
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end
        end
    end

    assign edge_e      = kb_clk_flt_d & ~kb_clk_flt;
    assign bit_b       = kb_data_p1;
    assign timeout_hit = (state != ST_IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES));

    // Stage: frame FSM and abort timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            to_cnt      <= '0;
            rx_timeout  <= 1'b0;
            push_vld_p1 <= 1'b0;
        end else begin
            rx_timeout  <= timeout_hit;
            push_vld_p1 <= 1'b0;
            if (timeout_hit) begin
                state  <= ST_IDLE;
                to_cnt <= '0;
            end else begin
                if (state == ST_IDLE || edge_e)
                    to_cnt <= '0;
                else
                    to_cnt <= to_cnt + TW'(1);
                if (edge_e) begin
                    case (state)
                        ST_IDLE: begin
                            if (!bit_b) begin
                                state   <= ST_DATA;
                                bit_cnt <= '0;
                            end
                        end
                        ST_DATA: begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                state <= ST_PARITY;
                        end
                        ST_PARITY: state <= ST_STOP;
                        ST_STOP: begin
                            push_vld_p1 <= 1'b1;
                            state       <= ST_IDLE;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (edge_e && !timeout_hit) begin
            case (state)
                ST_DATA:   shift_p0[bit_cnt] <= bit_b;
                ST_PARITY: perr_p0 <= parity_err(shift_p0, bit_b);
                ST_STOP:   push_word_p1 <= {~bit_b, perr_p0, shift_p0};
                default:   ;
            endcase
        end
    end

    // Stage: FWFT FIFO; a pop in the push cycle frees room for a full FIFO.
    assign full    = (rx_level == LW'(FIFO_DEPTH));
    assign pop     = rx_valid & rx_ready;
    assign push_ok = push_vld_p1 & (~full | pop);
    assign ovf_set = push_vld_p1 & full & ~pop;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_word_p1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rx_level    <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)
                rx_level <= rx_level + LW'(1);
            else if (pop && !push_ok)
                rx_level <= rx_level - LW'(1);
            if (ovf_set)
                rx_overflow <= 1'b1;
            else if (clr_ovf)
                rx_overflow <= 1'b0;
        end
    end

    // Head fields are forced to zero while empty so they never expose stale storage.
    assign rx_valid = (rx_level != '0);
    assign head     = mem[rd_ptr];
    assign rx_data  = rx_valid ? head[7:0] : 8'h00;
    assign rx_perr  = rx_valid ? head[8]   : 1'b0;
    assign rx_ferr  = rx_valid ? head[9]   : 1'b0;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames, error flags, overflow, timeout,
// glitch rejection, reset and simultaneous push/pop on a full FIFO.
module tb_ps2_rx_fifo;

    localparam int FL   = 4;
    localparam int DEP  = 4;
    localparam int TO   = 200;
    localparam int HALF = 20;

    logic       clk, rst, kb_clk, kb_data, rx_ready, clr_ovf;
    logic       rx_valid, rx_perr, rx_ferr, rx_overflow, rx_timeout;
    logic [7:0] rx_data;
    logic [2:0] rx_level;

    int checks = 0;
    int errors = 0;
    int to_seen = 0;
    int to_base;

    ps2_rx_fifo #(.FILTER_LEN(FL), .FIFO_DEPTH(DEP), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .kb_clk(kb_clk), .kb_data(kb_data),
        .rx_ready(rx_ready), .clr_ovf(clr_ovf), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
        .rx_level(rx_level), .rx_overflow(rx_overflow), .rx_timeout(rx_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (rx_timeout) to_seen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b, input bit glitch, input bit rdy_pulse);
        kb_data = b;
        if (glitch) begin
            repeat (HALF / 2) @(negedge clk);
            kb_clk = 1'b0;
            repeat (FL - 1) @(negedge clk);
            kb_clk = 1'b1;
            repeat (HALF / 2 - (FL - 1)) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        kb_clk = 1'b0;
        if (rdy_pulse) begin
            // Write cycle of the stop-bit push is FL+3 negedges after the fall.
            repeat (FL + 3) @(negedge clk);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
            repeat (HALF - FL - 4) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        kb_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int glitch_at, input bit rdy_at_stop);
        ps2_bit(1'b0, glitch_at == 0, 1'b0);
        for (int i = 0; i < 8; i++)
            ps2_bit(d[i], glitch_at == i + 1, 1'b0);
        ps2_bit(par, 1'b0, 1'b0);
        ps2_bit(stop, 1'b0, rdy_at_stop);
        kb_data = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        check({tag, "_valid"}, rx_valid, 1);
        check({tag, "_data"}, rx_data, d);
        check({tag, "_perr"}, rx_perr, pe);
        check({tag, "_ferr"}, rx_ferr, fe);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, rx_valid, 0);
        check({tag, "_data"}, rx_data, 0);
        check({tag, "_perr"}, rx_perr, 0);
        check({tag, "_ferr"}, rx_ferr, 0);
        check({tag, "_level"}, rx_level, 0);
        check({tag, "_ovf"}, rx_overflow, 0);
        check({tag, "_tmo"}, rx_timeout, 0);
    endtask

    initial begin
        rst = 1'b1; kb_clk = 1'b1; kb_data = 1'b1; rx_ready = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Clean frame 0x1C, parity 0, stop 1.
        send_frame(8'h1C, 1'b0, 1'b1, -1, 1'b0);
        check_head("clean", 8'h1C, 1'b0, 1'b0);
        check("clean_level", rx_level, 1);
        pop_one();
        check("clean_pop_level", rx_level, 0);
        check("clean_pop_valid", rx_valid, 0);

        // Parity error, then framing error.
        send_frame(8'h1C, 1'b1, 1'b1, -1, 1'b0);
        check_head("perr", 8'h1C, 1'b1, 1'b0);
        pop_one();
        send_frame(8'hF0, 1'b1, 1'b0, -1, 1'b0);
        check_head("ferr", 8'hF0, 1'b0, 1'b1);
        pop_one();

        // Overflow: five frames into a depth-4 FIFO.
        send_frame(8'h01, 1'b0, 1'b1, -1, 1'b0);
        send_frame(8'h02, 1'b0, 1'b1, -1, 1'b0);
        send_frame(8'h03, 1'b1, 1'b1, -1, 1'b0);
        send_frame(8'h04, 1'b0, 1'b1, -1, 1'b0);
        check("ovf_pre_flag", rx_overflow, 0);
        send_frame(8'h05, 1'b1, 1'b1, -1, 1'b0);
        check("ovf_level", rx_level, 4);
        check("ovf_flag", rx_overflow, 1);
        for (int i = 1; i <= 4; i++) begin
            check_head("ovf_drain", 8'(i), 1'b0, 1'b0);
            pop_one();
        end
        check("ovf_empty", rx_valid, 0);
        check("ovf_still_set", rx_overflow, 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_cleared", rx_overflow, 0);

        // Timeout: start plus three data bits, then idle.
        to_base = to_seen;
        ps2_bit(1'b0, 1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0, 1'b0);
        ps2_bit(1'b0, 1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0, 1'b0);
        kb_data = 1'b1;
        repeat (300) @(negedge clk);
        check("tmo_pulses", to_seen - to_base, 1);
        check("tmo_level", rx_level, 0);
        send_frame(8'hAA, 1'b1, 1'b1, -1, 1'b0);
        check_head("tmo_next", 8'hAA, 1'b0, 1'b0);
        check("tmo_next_level", rx_level, 1);
        pop_one();

        // Glitch rejection in idle (data low would look like a start bit).
        to_base = to_seen;
        kb_data = 1'b0;
        kb_clk = 1'b0;
        repeat (FL - 1) @(negedge clk);
        kb_clk = 1'b1;
        repeat (250) @(negedge clk);
        kb_data = 1'b1;
        check("glitch_idle_tmo", to_seen - to_base, 0);
        check("glitch_idle_level", rx_level, 0);
        // Glitch mid-frame, before data bit 4.
        send_frame(8'h5A, 1'b1, 1'b1, 5, 1'b0);
        check_head("glitch_frame", 8'h5A, 1'b0, 1'b0);
        check("glitch_level", rx_level, 1);
        pop_one();

        // Reset mid-frame with two entries queued.
        send_frame(8'h11, 1'b1, 1'b1, -1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1, -1, 1'b0);
        check("rst_pre_level", rx_level, 2);
        ps2_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst1");
        rst = 1'b0;
        kb_data = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h12, 1'b1, 1'b1, -1, 1'b0);
        check_head("rst_next", 8'h12, 1'b0, 1'b0);
        check("rst_next_level", rx_level, 1);
        pop_one();

        // Simultaneous push and pop on a full FIFO.
        send_frame(8'h31, 1'b0, 1'b1, -1, 1'b0);
        send_frame(8'h32, 1'b0, 1'b1, -1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b1, -1, 1'b0);
        send_frame(8'h34, 1'b0, 1'b1, -1, 1'b0);
        check("pp_full_level", rx_level, 4);
        send_frame(8'h35, 1'b1, 1'b1, -1, 1'b1);
        check("pp_level", rx_level, 4);
        check("pp_ovf", rx_overflow, 0);
        for (int i = 2; i <= 5; i++) begin
            check_head("pp_drain", 8'(8'h30 + i), 1'b0, 1'b0);
            pop_one();
        end
        check("pp_empty_valid", rx_valid, 0);
        check("pp_empty_level", rx_level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver for the keyboard/mouse front end. It runs entirely in the system clock domain: it synchronises and deglitches the raw `kb_clk`/`kb_data` lines, decodes 11-bit frames, and checks odd parity and the stop bit. Each received byte and its error flags are queued in a first-word-fall-through FIFO with a valid/ready read port. Frame-abort timeout and FIFO overflow reporting are included, so downstream logic never has to track raw PS/2 timing.

## Interface
- `FILTER_LEN`, 8: consecutive identical synchronised samples required before filtered `kb_clk` changes (≥1).
- `FIFO_DEPTH`, 16: number of queued entries; power of 2, ≥2.
- `TIMEOUT_CYCLES`, 100000: maximum `clk` cycles between filtered `kb_clk` falling edges inside a frame.
- `clk`  in  1  system clock; every register is clocked on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `kb_clk`  in  1  raw PS/2 clock line, asynchronous.
- `kb_data`  in  1  raw PS/2 data line, asynchronous.
- `rx_ready`  in  1  consumer accepts the head entry.
- `clr_ovf`  in  1  one-cycle pulse that clears `rx_overflow`.
- `rx_valid`  out  1  FIFO non-empty; head entry is presented.
- `rx_data`  out  8  head entry's data byte.
- `rx_perr`  out  1  head entry failed odd parity.
- `rx_ferr`  out  1  head entry's stop bit was 0.
- `rx_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `rx_overflow`  out  1  sticky flag: a completed frame was dropped because the FIFO was full.
- `rx_timeout`  out  1  one-cycle pulse when a partial frame is aborted.

## Operation
- **Input conditioning**
  - Each of `kb_clk` and `kb_data` passes through a 2-FF synchroniser.
  - Synchronised `kb_clk` feeds a filter. The filtered value takes the new level only after `FILTER_LEN` consecutive equal samples that differ from the current filtered value.
  - Filtered clock resets to 1.
  - Edge event E: filtered clock transitions 1→0. In the same cycle, synchronised `kb_data` is sampled as bit b.
- **Frame FSM**, advancing on E only:
  - IDLE: b=0 → DATA with cnt=0. b=1 → stay in IDLE (spurious edge, ignored).
  - DATA: shift register stores b at index cnt (LSB first); cnt increments. After the 8th bit → PARITY.
  - PARITY: perr = ~(^data ^ b), i.e. set when the total count of ones is even. → STOP.
  - STOP: ferr = ~b. Push {ferr, perr, data} to the FIFO. → IDLE.
- **Timeout**
  - In any state other than IDLE, a counter resets on every E and otherwise increments.
  - When it reaches `TIMEOUT_CYCLES`: FSM → IDLE, partial frame discarded with no push, `rx_timeout` high for one cycle.
- **FIFO**
  - Pop when `rx_valid && rx_ready`.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the entry is dropped and `rx_overflow` is set.
  - `rx_overflow` clears on `clr_ovf`. If set and clear occur in the same cycle, set wins.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `rx_level` is +1 on push only, −1 on pop only, and unchanged on simultaneous push and pop.
  - `rx_data`/`rx_perr`/`rx_ferr` are undefined-but-stable when `rx_valid`=0 and must not be consumed.
- **Reset**
  - Asserting `rst` mid-frame or mid-transfer immediately discards the frame and empties the FIFO.
  - Reset values: `rx_valid`=0, `rx_data`=0, `rx_perr`=0, `rx_ferr`=0, `rx_level`=0, `rx_overflow`=0, `rx_timeout`=0.
  - Also reset: FSM=IDLE, cnt=0, timeout counter=0, synchronisers=1.

## Timing
- **Edge detection latency:** E occurs 2 + `FILTER_LEN` + 1 cycles after a clean falling transition on raw `kb_clk`, plus at most 1 cycle of synchroniser uncertainty.
- **Stop-bit to output:** if E (stop bit) occurs in cycle n, the push takes effect at the end of n+1. `rx_valid` and the new `rx_level` are visible in cycle n+2 when the FIFO was empty.
- **Pop:** a pop in cycle m presents the next entry in cycle m+1 (FWFT). `rx_valid` drops in m+1 if that was the last entry.
- **Back-to-back pops:** `rx_ready` held high drains one entry per cycle.
- **`rx_timeout`:** asserted in the cycle after the counter reaches `TIMEOUT_CYCLES`. An E in that same cycle is treated as a new IDLE-state edge.
- **Throughput:** the PS/2 bit rate (10–16.7 kHz) is far below `clk`. No back-pressure reaches the PS/2 side.

## Test plan
- **Clean frame:** `FILTER_LEN`=4. Frame 0x1C with parity bit 0 and stop bit 1. Expect `rx_valid`=1, `rx_data`=0x1C, `rx_perr`=0, `rx_ferr`=0, `rx_level`=1. Pulse `rx_ready` and expect `rx_level`=0, `rx_valid`=0.
- **Parity and stop errors:** 0x1C sent with parity bit 1 → entry `rx_perr`=1, `rx_ferr`=0. Then 0xF0 sent with parity 1 and stop bit 0 → `rx_perr`=0, `rx_ferr`=1.
- **Overflow:** `FIFO_DEPTH`=4, `rx_ready`=0. Send 0x01..0x05.
  - Expect `rx_level`=4, `rx_overflow`=1, with 0x05 lost.
  - Drain and expect 0x01..0x04 in order.
  - Pulse `clr_ovf` and expect `rx_overflow`=0.
- **Timeout:** `TIMEOUT_CYCLES`=200. Send start plus 3 data bits, then hold `kb_clk` high.
  - Expect exactly one `rx_timeout` pulse, no push, and `rx_level`=0.
  - A following 0xAA frame (parity 1) is received correctly.
- **Glitch rejection:** `kb_clk` low pulses of `FILTER_LEN`−1 cycles, both in IDLE and mid-frame, cause no state change. A normal 0x5A frame afterwards decodes correctly.
- **Reset and simultaneous push/pop:**
  - Assert `rst` after the 5th data bit with 2 entries queued. Expect every output at its reset value; the next frame 0x12 is received correctly.
  - With the FIFO full and `rx_ready`=1 in the push cycle, expect the push to be accepted, `rx_level` unchanged, and `rx_overflow`=0.
